snn_input_loader: RTL and testbench

Image-side front end for `snn_core`. Accepts a 784-pixel binary image as 98 bytes over a valid/ready byte stream and stores it in an internal 784×1 buffer. Once loaded, it pulses `start` to the core and serves the core's pixel reads on `addr_input_unit`/`q_input`. It then captures `digit` on `done` and holds it on a result handshake until acknowledged.

---
 rtl/snn_input_loader.sv | 148 ++++++++++++++
 tb/tb_snn_input_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_input_loader.sv
// snn_input_loader: image-side front end for snn_core.
// Receives a 784-pixel binary image as 98 LSB-first bytes on a valid/ready
// stream and buffers it. After the last byte it pulses start, serves the
// core's pixel reads with one-cycle latency, captures digit on done, and
// holds it on a result/ack handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   rx_data/valid/ready  pixel byte stream (ready is combinational)
//   load_clr             abort/resync back to LOAD
//   addr_input_unit      core pixel read address
//   q_input              registered pixel read data
//   start                one-cycle core start pulse
//   done, digit          core completion and classification
//   result, result_valid held classification
//   result_ack           consumer acknowledge
module snn_input_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned NUM_BYTES  = 98
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       load_clr,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       done,
    input  logic [3:0] digit,
    output logic [3:0] result,
    output logic       result_valid,
    input  logic       result_ack
);
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ADDR_W = 10;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             q_input_q, q_input_d;
    logic             start_q, start_d;
    logic [3:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             pix_we;
    logic             accept;
    logic [7:0]       pix_mem [NUM_BYTES];

    // Ready depends only on state, load_clr and reset, never on rx_valid.
    assign rx_ready = rst_n && (state_q == LOAD) && !load_clr;
    assign accept   = rx_ready && rx_valid;

    // Next-state and register updates; load_clr overrides every other event.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        pix_we         = 1'b0;
        if (load_clr) begin
            state_d        = LOAD;
            byte_cnt_d     = '0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        pix_we = 1'b1;
                        if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = START;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
                START: begin
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        result_d       = digit;
                        result_valid_d = 1'b1;
                        state_d        = RESULT;
                    end
                end
                RESULT: begin
                    if (result_ack) begin
                        result_valid_d = 1'b0;
                        state_d        = LOAD;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
        // Registered so start is high exactly during the START cycle.
        start_d = (state_d == START);
    end

    // Pixel read: word a[9:3], bit a[2:0]; out-of-image addresses read 0.
    always_comb begin
        q_input_d = 1'b0;
        if (addr_input_unit < ADDR_W'(NUM_PIXELS)) begin
            q_input_d = pix_mem[addr_input_unit[9:3]][addr_input_unit[2:0]];
        end
    end

    // Image buffer, written only on accepted bytes in LOAD.
    always_ff @(posedge clk) begin
        if (pix_we) begin
            pix_mem[byte_cnt_q] <= rx_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            byte_cnt_q     <= '0;
            q_input_q      <= 1'b0;
            start_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            q_input_q      <= q_input_d;
            start_q        <= start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign q_input      = q_input_q;
    assign start        = start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Testbench for snn_input_loader: directed image loads, pixel read tables,
// result handshake, load_clr resync and mid-run reset.
module tb_snn_input_loader;
    localparam int unsigned NUM_PIXELS = 784;
    localparam int unsigned NUM_BYTES  = 98;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       load_clr;
    logic [9:0] addr_input_unit;
    logic       q_input;
    logic       start;
    logic       done;
    logic [3:0] digit;
    logic [3:0] result;
    logic       result_valid;
    logic       result_ack;

    int nvec = 0;
    int nmis = 0;
    logic [7:0] img [NUM_BYTES];

    typedef struct {
        logic [9:0] addr;
        logic       exp_q;
    } rd_vec_t;

    rd_vec_t vecs [12];

    snn_input_loader #(
        .NUM_PIXELS(NUM_PIXELS),
        .NUM_BYTES (NUM_BYTES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .load_clr       (load_clr),
        .addr_input_unit(addr_input_unit),
        .q_input        (q_input),
        .start          (start),
        .done           (done),
        .digit          (digit),
        .result         (result),
        .result_valid   (result_valid),
        .result_ack     (result_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at the negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream img[] into the DUT, optionally with idle gaps, and verify the start pulse.
    task automatic send_image(input bit gaps);
        int early;
        early = 0;
        for (int k = 0; k < int'(NUM_BYTES); k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(2, 0);
                repeat (g) begin
                    rx_valid = 1'b0;
                    step();
                    if (start === 1'b1) early++;
                end
            end
            rx_valid = 1'b1;
            rx_data  = img[k];
            #1;
            check("rx_ready_load", rx_ready, 1);
            step();
            if (k < int'(NUM_BYTES) - 1 && start === 1'b1) early++;
        end
        rx_valid = 1'b0;
        check("start_early", early, 0);
        check("start_pulse", start, 1);
        #1;
        check("rx_ready_start", rx_ready, 0);
        step();
        check("start_once", start, 0);
    endtask

    task automatic apply_table(input string name);
        for (int i = 0; i < 12; i++) begin
            addr_input_unit = vecs[i].addr;
            step();
            check(name, q_input, vecs[i].exp_q);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < int'(NUM_PIXELS); a++) begin
            addr_input_unit = 10'(a);
            step();
            check("q_pixel", q_input, img[a / 8][a % 8]);
        end
        addr_input_unit = 10'd784;
        step();
        check("q_784", q_input, 0);
        addr_input_unit = 10'd1023;
        step();
        check("q_1023", q_input, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pattern 0xA5 = 1010_0101, read LSB first.
        vecs[0]  = '{10'd0,    1'b1};
        vecs[1]  = '{10'd1,    1'b0};
        vecs[2]  = '{10'd2,    1'b1};
        vecs[3]  = '{10'd3,    1'b0};
        vecs[4]  = '{10'd4,    1'b0};
        vecs[5]  = '{10'd5,    1'b1};
        vecs[6]  = '{10'd6,    1'b0};
        vecs[7]  = '{10'd7,    1'b1};
        vecs[8]  = '{10'd783,  1'b1};
        vecs[9]  = '{10'd776,  1'b1};
        vecs[10] = '{10'd784,  1'b0};
        vecs[11] = '{10'd1023, 1'b0};

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; load_clr = 1'b0;
        addr_input_unit = '0; done = 1'b0; digit = '0; result_ack = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rx_ready_in_reset", rx_ready, 0);
        step();
        check("q_reset", q_input, 0);
        check("start_reset", start, 0);
        check("result_reset", result, 0);
        check("rv_reset", result_valid, 0);
        rst_n = 1'b1;
        #1;
        check("rx_ready_after_reset", rx_ready, 1);

        // Image 1: 0xA5 everywhere at full rate.
        for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'hA5;
        send_image(1'b0);
        apply_table("q_a5");

        // WAIT_DONE ignores rx_valid and result_ack.
        rx_valid = 1'b1; rx_data = 8'h00; result_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rx_ready_wait", rx_ready, 0);
            step();
            check("rv_wait", result_valid, 0);
        end
        rx_valid = 1'b0; result_ack = 1'b0;
        apply_table("q_a5_frozen");

        // Capture digit 7.
        done = 1'b1; digit = 4'd7;
        step();
        done = 1'b0;
        check("result_7", result, 7);
        check("rv_set", result_valid, 1);

        // Held for 20 cycles without ack; a stray done is ignored.
        digit = 4'd3;
        for (int i = 0; i < 20; i++) begin
            done = (i == 5);
            step();
            check("result_hold", result, 7);
            check("rv_hold", result_valid, 1);
        end
        done = 1'b0;
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check("rv_cleared", result_valid, 0);
        #1;
        check("rx_ready_after_ack", rx_ready, 1);

        // Image 2: byte k = k with random gaps.
        for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'(k);
        send_image(1'b1);
        read_all();
        done = 1'b1; digit = 4'd5;
        step();
        done = 1'b0;
        check("result_5", result, 5);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check("rv_cleared_2", result_valid, 0);

        // Partial load of 50 bytes then load_clr.
        for (int k = 0; k < 50; k++) begin
            rx_valid = 1'b1; rx_data = 8'hFF;
            step();
        end
        load_clr = 1'b1;
        #1;
        check("rx_ready_clr", rx_ready, 0);
        step();
        load_clr = 1'b0; rx_valid = 1'b0;
        check("rv_clr", result_valid, 0);
        check("start_clr", start, 0);
        for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'(k) ^ 8'h3C;
        send_image(1'b0);
        read_all();

        // Reset mid WAIT_DONE.
        addr_input_unit = 10'd2;
        step();
        check("q_pre_reset", q_input, 1);
        rst_n = 1'b0;
        #1;
        check("rx_ready_mid_reset", rx_ready, 0);
        step();
        rst_n = 1'b1;
        check("q_mid_reset", q_input, 0);
        check("start_mid_reset", start, 0);
        check("result_mid_reset", result, 0);
        check("rv_mid_reset", result_valid, 0);
        #1;
        check("rx_ready_post_reset", rx_ready, 1);
        done = 1'b1; digit = 4'd9;
        step();
        done = 1'b0;
        check("rv_done_ignored", result_valid, 0);
        check("result_done_ignored", result, 0);
        step();
        check("rv_done_ignored_2", result_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
